// File: rtl/layer_ctrl_pkg.sv
// Shared types and helpers for the per-layer control sequencer (control_layer_seq).
package layer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } layer_state_t;

  // Next pool position along one axis; wraps to 0 after the last index.
  function automatic int unsigned pool_step(input int unsigned pos, input int unsigned last);
    return (pos >= last) ? 32'd0 : pos + 32'd1;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Shift-register valid chain: taps[i] is din delayed i+1 cycles, last is the deepest tap.
module valid_delay_line #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [DEPTH-1:0] taps,
  output logic             last
);

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge clk) begin
      if (!rst) taps <= '0;
      else      taps <= din;
    end
  end else begin : g_many
    always_ff @(posedge clk) begin
      if (!rst) taps <= '0;
      else      taps <= {taps[DEPTH-2:0], din};
    end
  end

  assign last = taps[DEPTH-1];

endmodule

// File: rtl/control_layer_seq.sv
// Per-layer control sequencer: padded scan, window valid, conv/bias valid chains, 2x2 pool strobes.
// Optional protocol checker on err is built only when CTRL_LAYER_PROTO_CHECK_EN is defined.
//
//   state    | meaning
//   ST_IDLE  | waiting for start; no beats, counters at 0
//   ST_SCAN  | walking the padded frame row-major, one beat per pad cycle or accepted pixel
//   ST_DRAIN | scan finished; waiting for valid chains and pool output to empty
module control_layer_seq
  import layer_ctrl_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int HEIGHT   = 5,
  parameter int PAD      = 1,
  parameter int CONV_LAT = 4,
  parameter int BIAS_LAT = 6,
  parameter int POOL     = 1,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                valid_in,
  output logic                in_ready,
  output logic                padding_valid,
  output logic [CNT_W-1:0]    counter_col,
  output logic [CNT_W-1:0]    counter_row,
  output logic                valid_in_pipeline2D,
  output logic [CONV_LAT-1:0] valid_pipeline2D,
  output logic                valid_in_bias,
  output logic [BIAS_LAT-1:0] valid_pipeline_bias,
  output logic                valid_in_maxpooling,
  output logic                valid_in_max,
  output logic                valid_in_max1,
  output logic                valid_out,
  output logic                busy,
  output logic                frame_done,
  output logic                err
);

  localparam int PW = WIDTH + 2 * PAD;
  localparam int PH = HEIGHT + 2 * PAD;
  localparam int unsigned OW_LAST_U = PW - 3;
  localparam int unsigned OH_LAST_U = PH - 3;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
  localparam logic [CNT_W-1:0] COL_LAST  = CNT_W'(PW - 1);
  localparam logic [CNT_W-1:0] ROW_LAST  = CNT_W'(PH - 1);
  localparam logic [CNT_W-1:0] PAD_LO    = CNT_W'(PAD);
  localparam logic [CNT_W-1:0] COL_PAD_HI = CNT_W'(PW - PAD);
  localparam logic [CNT_W-1:0] ROW_PAD_HI = CNT_W'(PH - PAD);
  localparam logic [CNT_W-1:0] OW_LAST   = CNT_W'(PW - 3);

  function automatic logic pad_at(input logic [CNT_W-1:0] r, input logic [CNT_W-1:0] c);
    return (r < PAD_LO) || (r >= ROW_PAD_HI) || (c < PAD_LO) || (c >= COL_PAD_HI);
  endfunction

  layer_state_t     state, state_nx;
  logic [CNT_W-1:0] col_nx, row_nx;
  logic             beat, last_beat, window, chains_empty, pool_strobe;

  // padding_valid/in_ready already describe the pending position, so a beat needs no decode here.
  assign beat      = (state == ST_SCAN) && (padding_valid || valid_in);
  assign last_beat = beat && (counter_row == ROW_LAST) && (counter_col == COL_LAST);
  assign window    = beat && (counter_row >= TWO) && (counter_col >= TWO);

  assign chains_empty = !valid_in_pipeline2D && !(|valid_pipeline2D) &&
                        !(|valid_pipeline_bias) && !valid_out;

  always_comb begin
    state_nx = state;
    col_nx   = counter_col;
    row_nx   = counter_row;
    case (state)
      ST_IDLE: if (start) state_nx = ST_SCAN;
      ST_SCAN: begin
        if (last_beat) begin
          state_nx = ST_DRAIN;
          col_nx   = '0;
          row_nx   = '0;
        end else if (beat) begin
          if (counter_col == COL_LAST) begin
            col_nx = '0;
            row_nx = counter_row + ONE;
          end else begin
            col_nx = counter_col + ONE;
          end
        end
      end
      ST_DRAIN: if (chains_empty) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= ST_IDLE;
      counter_col         <= '0;
      counter_row         <= '0;
      padding_valid       <= 1'b0;
      in_ready            <= 1'b0;
      busy                <= 1'b0;
      frame_done          <= 1'b0;
      valid_in_pipeline2D <= 1'b0;
      valid_out           <= 1'b0;
    end else begin
      state               <= state_nx;
      counter_col         <= col_nx;
      counter_row         <= row_nx;
      padding_valid       <= (state_nx == ST_SCAN) && pad_at(row_nx, col_nx);
      in_ready            <= (state_nx == ST_SCAN) && !pad_at(row_nx, col_nx);
      busy                <= (state_nx != ST_IDLE);
      frame_done          <= (state == ST_DRAIN) && chains_empty;
      valid_in_pipeline2D <= window;
      valid_out           <= pool_strobe;
    end
  end

  valid_delay_line #(.DEPTH(CONV_LAT)) u_conv_chain (
    .clk  (clk),
    .rst  (rst),
    .din  (valid_in_pipeline2D),
    .taps (valid_pipeline2D),
    .last (valid_in_bias)
  );

  valid_delay_line #(.DEPTH(BIAS_LAT)) u_bias_chain (
    .clk  (clk),
    .rst  (rst),
    .din  (valid_in_bias),
    .taps (valid_pipeline_bias),
    .last (valid_in_maxpooling)
  );

  if (POOL != 0) begin : g_pool
    logic [CNT_W-1:0] pool_col, pool_row;

    // Odd trailing column/row is still counted so the next row starts aligned.
    always_ff @(posedge clk) begin
      if (!rst) begin
        pool_col <= '0;
        pool_row <= '0;
      end else if (valid_in_maxpooling) begin
        pool_col <= CNT_W'(pool_step(32'(pool_col), OW_LAST_U));
        if (pool_col == OW_LAST)
          pool_row <= CNT_W'(pool_step(32'(pool_row), OH_LAST_U));
      end
    end

    assign valid_in_max  = valid_in_maxpooling & pool_col[0];
    assign valid_in_max1 = valid_in_max & pool_row[0];
    assign pool_strobe   = valid_in_max1;
  end else begin : g_bypass
    assign valid_in_max  = 1'b0;
    assign valid_in_max1 = 1'b0;
    assign pool_strobe   = valid_in_maxpooling;
  end

`ifdef CTRL_LAYER_PROTO_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst)
      err <= 1'b0;
    else if (((state == ST_SCAN) && valid_in && !in_ready) || (start && (state != ST_IDLE)))
      err <= 1'b1;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_control_layer_seq.sv
// Self-checking bench for control_layer_seq: three geometries checked every cycle against a frame-level model.
module tb_control_layer_seq;

  localparam int CL = 4;
  localparam int BL = 6;
  localparam int CW = 16;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0] rst_v, start_v, vin_v;
  logic [NI-1:0] ir_w, pv_w, vip_w, vib_w, vimp_w, vm_w, vm1_w, vo_w, busy_w, fd_w, err_w;
  logic [CW-1:0] col_w [NI];
  logic [CW-1:0] row_w [NI];
  logic [CL-1:0] conv_w [NI];
  logic [BL-1:0] bias_w [NI];

  // inst0: 4x4 pad1 pool; inst1: 5x5 no pad, pool; inst2: 4x4 pad1, pool bypass
  int cfg_w[NI]    = '{4, 5, 4};
  int cfg_h[NI]    = '{4, 5, 4};
  int cfg_pad[NI]  = '{1, 0, 1};
  int cfg_pool[NI] = '{1, 1, 0};

  genvar gi;
  for (gi = 0; gi < NI; gi++) begin : g_dut
    control_layer_seq #(
      .WIDTH   ((gi == 1) ? 5 : 4),
      .HEIGHT  ((gi == 1) ? 5 : 4),
      .PAD     ((gi == 1) ? 0 : 1),
      .CONV_LAT(CL),
      .BIAS_LAT(BL),
      .POOL    ((gi == 2) ? 0 : 1),
      .CNT_W   (CW)
    ) dut (
      .clk                (clk),
      .rst                (rst_v[gi]),
      .start              (start_v[gi]),
      .valid_in           (vin_v[gi]),
      .in_ready           (ir_w[gi]),
      .padding_valid      (pv_w[gi]),
      .counter_col        (col_w[gi]),
      .counter_row        (row_w[gi]),
      .valid_in_pipeline2D(vip_w[gi]),
      .valid_pipeline2D   (conv_w[gi]),
      .valid_in_bias      (vib_w[gi]),
      .valid_pipeline_bias(bias_w[gi]),
      .valid_in_maxpooling(vimp_w[gi]),
      .valid_in_max       (vm_w[gi]),
      .valid_in_max1      (vm1_w[gi]),
      .valid_out          (vo_w[gi]),
      .busy               (busy_w[gi]),
      .frame_done         (fd_w[gi]),
      .err                (err_w[gi])
    );
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: mode 0 idle, 1 scanning, 2 draining; p = linear padded position
  int mode[NI], p[NI], fd[NI], last_ev[NI];
  bit armed[NI], err_m[NI];
  bit ev_vip[NI][256];
  logic [CL-1:0] ev_conv[NI][256];
  logic [BL-1:0] ev_bias[NI][256];
  bit ev_max[NI][256], ev_max1[NI][256], ev_vo[NI][256];

  int n_pad[NI], n_acc[NI], n_vip[NI], n_vo[NI], n_fd[NI];
  int b_pad[NI], b_acc[NI], b_vip[NI], b_vo[NI], b_fd[NI];

  task automatic chk(input string nm, input int id, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s inst%0d cyc%0d: got %0h expected %0h", nm, id, cyc, act, exp);
    end
  endtask

  task automatic clear_ring(input int i);
    for (int j = 0; j < 256; j++) begin
      ev_vip[i][j] = 0; ev_conv[i][j] = '0; ev_bias[i][j] = '0;
      ev_max[i][j] = 0; ev_max1[i][j] = 0; ev_vo[i][j] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NI; i++) begin
      int pw, ph, ow, r, c, s, k, pc, pr, t, last;
      bit pad, strobe, e_err;
      pw = cfg_w[i] + 2 * cfg_pad[i];
      ph = cfg_h[i] + 2 * cfg_pad[i];
      ow = pw - 2;
      s  = cyc % 256;
      r  = p[i] / pw;
      c  = p[i] % pw;
      pad = (mode[i] == 1) && (r < cfg_pad[i] || r >= ph - cfg_pad[i] ||
                               c < cfg_pad[i] || c >= pw - cfg_pad[i]);
`ifdef CTRL_LAYER_PROTO_CHECK_EN
      e_err = err_m[i];
`else
      e_err = 1'b0;
`endif
      if (armed[i]) begin
        chk("busy", i, busy_w[i], mode[i] != 0);
        chk("padding_valid", i, pv_w[i], pad);
        chk("in_ready", i, ir_w[i], (mode[i] == 1) && !pad);
        chk("counter_col", i, col_w[i], (mode[i] == 1) ? c : 0);
        chk("counter_row", i, row_w[i], (mode[i] == 1) ? r : 0);
        chk("valid_in_pipeline2D", i, vip_w[i], ev_vip[i][s]);
        chk("valid_pipeline2D", i, conv_w[i], ev_conv[i][s]);
        chk("valid_in_bias", i, vib_w[i], ev_conv[i][s][CL-1]);
        chk("valid_pipeline_bias", i, bias_w[i], ev_bias[i][s]);
        chk("valid_in_maxpooling", i, vimp_w[i], ev_bias[i][s][BL-1]);
        chk("valid_in_max", i, vm_w[i], ev_max[i][s]);
        chk("valid_in_max1", i, vm1_w[i], ev_max1[i][s]);
        chk("valid_out", i, vo_w[i], ev_vo[i][s]);
        chk("frame_done", i, fd_w[i], cyc == fd[i]);
        chk("err", i, err_w[i], e_err);
        n_pad[i] += int'(pv_w[i]);
        n_acc[i] += int'(ir_w[i] & vin_v[i]);
        n_vip[i] += int'(vip_w[i]);
        n_vo[i]  += int'(vo_w[i]);
        n_fd[i]  += int'(fd_w[i]);
      end
      if (!rst_v[i]) begin
        mode[i] = 0; p[i] = 0; fd[i] = -1; err_m[i] = 0; armed[i] = 1;
        clear_ring(i);
      end else if (armed[i]) begin
        if (mode[i] == 0) begin
          if (start_v[i]) begin mode[i] = 1; p[i] = 0; end
        end else if (mode[i] == 1) begin
          if (start_v[i]) err_m[i] = 1;
          if (vin_v[i] && pad) err_m[i] = 1;
          if (pad || vin_v[i]) begin
            if (r >= 2 && c >= 2) begin
              k  = (r - 2) * ow + (c - 2);
              pc = k % ow;
              pr = k / ow;
              ev_vip[i][(cyc + 1) % 256] = 1;
              for (int j = 0; j < CL; j++) ev_conv[i][(cyc + 2 + j) % 256][j] = 1'b1;
              for (int j = 0; j < BL; j++) ev_bias[i][(cyc + 2 + CL + j) % 256][j] = 1'b1;
              t = cyc + 1 + CL + BL;
              if (cfg_pool[i] != 0) begin
                ev_max[i][t % 256]  = (pc % 2 == 1);
                ev_max1[i][t % 256] = (pc % 2 == 1) && (pr % 2 == 1);
                strobe = (pc % 2 == 1) && (pr % 2 == 1);
              end else begin
                strobe = 1;
              end
              if (strobe) begin ev_vo[i][(t + 1) % 256] = 1; last = t + 1; end
              else last = t;
              if (last > last_ev[i]) last_ev[i] = last;
            end
            if (p[i] == pw * ph - 1) begin
              mode[i] = 2;
              fd[i] = ((last_ev[i] > cyc) ? last_ev[i] : cyc) + 2;
            end else begin
              p[i]++;
            end
          end
        end else begin
          if (start_v[i]) err_m[i] = 1;
          if (cyc + 1 == fd[i]) mode[i] = 0;
        end
      end
      ev_vip[i][s] = 0; ev_conv[i][s] = '0; ev_bias[i][s] = '0;
      ev_max[i][s] = 0; ev_max1[i][s] = 0; ev_vo[i][s] = 0;
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap(input int id);
    b_pad[id] = n_pad[id]; b_acc[id] = n_acc[id]; b_vip[id] = n_vip[id];
    b_vo[id] = n_vo[id]; b_fd[id] = n_fd[id];
  endtask

  task automatic check_counts(input int id, input int e_pad, input int e_acc, input int e_vip,
                              input int e_vo);
    chk("pad_beat_count", id, n_pad[id] - b_pad[id], e_pad);
    chk("accept_count", id, n_acc[id] - b_acc[id], e_acc);
    chk("window_count", id, n_vip[id] - b_vip[id], e_vip);
    chk("valid_out_count", id, n_vo[id] - b_vo[id], e_vo);
    chk("frame_done_count", id, n_fd[id] - b_fd[id], 1);
    chk("busy_after_frame", id, busy_w[id], 0);
  endtask

  // Starts a frame and runs until frame_done; records first beat (2,2), first window, first pool input.
  task automatic run_frame(input int id, input bit toggle, output int t22, output int tvip,
                           output int tvimp);
    int n;
    bit done;
    snap(id);
    t22 = -1; tvip = -1; tvimp = -1; done = 0; n = 0;
    start_v[id] = 1'b1; vin_v[id] = 1'b1;
    cycle();
    start_v[id] = 1'b0;
    while (!done && n < 600) begin
      if (toggle) vin_v[id] = ~vin_v[id];
      start_v[id] = toggle && (n == 10);
      if (t22 < 0 && ir_w[id] && vin_v[id] && col_w[id] == 2 && row_w[id] == 2) t22 = n;
      if (tvip < 0 && vip_w[id]) tvip = n;
      if (tvimp < 0 && vimp_w[id]) tvimp = n;
      if (fd_w[id]) done = 1;
      else begin
        cycle();
        n++;
      end
    end
    chk("frame_done_within_budget", id, done, 1);
    start_v[id] = 1'b0; vin_v[id] = 1'b0;
    cycle();
  endtask

  initial begin
    int t22, tvip, tvimp;
    for (int i = 0; i < NI; i++) begin
      mode[i] = 0; p[i] = 0; fd[i] = -1; last_ev[i] = 0; armed[i] = 0; err_m[i] = 0;
      n_pad[i] = 0; n_acc[i] = 0; n_vip[i] = 0; n_vo[i] = 0; n_fd[i] = 0;
      clear_ring(i);
    end
    rst_v = '0; start_v = '0; vin_v = '0;
    repeat (3) cycle();
    chk("reset_busy", 0, busy_w, 0);
    chk("reset_counter_col", 0, col_w[0], 0);
    rst_v = '1;
    repeat (2) cycle();

    // full frame, valid_in held high
    run_frame(0, 1'b0, t22, tvip, tvimp);
    check_counts(0, 20, 16, 16, 4);
    chk("window_after_beat22", 0, tvip - t22, 1);
    chk("pool_in_after_window", 0, tvimp - tvip, 10);
`ifdef CTRL_LAYER_PROTO_CHECK_EN
    chk("err_sticky_after_pad_valid", 0, err_w[0], 1);
`else
    chk("err_tied_low", 0, err_w[0], 0);
`endif

    // valid_in toggling plus an ignored start mid-frame
    run_frame(0, 1'b1, t22, tvip, tvimp);
    check_counts(0, 20, 16, 16, 4);

    // no padding, odd pooled geometry
    run_frame(1, 1'b0, t22, tvip, tvimp);
    check_counts(1, 0, 25, 9, 1);

    // pool bypass
    run_frame(2, 1'b0, t22, tvip, tvimp);
    check_counts(2, 20, 16, 16, 16);

    // reset while the beat at index 20 is pending
    start_v[0] = 1'b1; vin_v[0] = 1'b1;
    cycle();
    start_v[0] = 1'b0;
    repeat (20) cycle();
    chk("busy_before_reset", 0, busy_w[0], 1);
    rst_v[0] = 1'b0;
    cycle();
    rst_v[0] = 1'b1; vin_v[0] = 1'b0;
    chk("post_reset_busy", 0, busy_w[0], 0);
    chk("post_reset_counter_row", 0, row_w[0], 0);
    chk("post_reset_window", 0, vip_w[0], 0);
    chk("post_reset_err", 0, err_w[0], 0);
    repeat (15) cycle();
    run_frame(0, 1'b0, t22, tvip, tvimp);
    check_counts(0, 20, 16, 16, 4);
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_layer_seq.md
Name: control_layer_seq

Overview:
Parametrised per-layer control sequencer for the convolution datapath. It generates padding/scan counters, 3x3-window valid, the convolution and bias pipeline valid chains, and 2x2 max-pool strobes from one FSM. It adds what fixed-geometry layer control lacks: configurable geometry and latencies, optional padding and pooling, an input ready handshake, a drain phase and a frame-done pulse.

Parameters:
WIDTH, 5, input feature-map columns (>=2)
HEIGHT, 5, input feature-map rows (>=2)
PAD, 1, zero-padding border (0 or 1)
CONV_LAT, 4, convolution pipeline depth in cycles (>=1)
BIAS_LAT, 6, bias/activation pipeline depth in cycles (>=1)
POOL, 1, 1 = 2x2 stride-2 max-pool strobes; 0 = bypass
CNT_W, 16, counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-low reset
start  in  1  frame start pulse; honoured only in IDLE
valid_in  in  1  upstream pixel valid
in_ready  out  1  block accepts a pixel this cycle
padding_valid  out  1  current beat is a padding position
counter_col  out  CNT_W  column of current beat in padded frame
counter_row  out  CNT_W  row of current beat in padded frame
valid_in_pipeline2D  out  1  3x3 window complete
valid_pipeline2D  out  CONV_LAT  conv pipeline valid chain
valid_in_bias  out  1  conv result valid
valid_pipeline_bias  out  BIAS_LAT  bias pipeline valid chain
valid_in_maxpooling  out  1  bias/activation result valid
valid_in_max  out  1  horizontal pool pair complete
valid_in_max1  out  1  2x2 pool block complete
valid_out  out  1  layer output valid
busy  out  1  not IDLE
frame_done  out  1  one-cycle pulse at end of frame
err  out  1  sticky protocol error (see optional feature)

Behaviour:
- Reset (rst=0 at clk edge): all outputs 0, counters 0, FSM IDLE, delay chains cleared; overrides everything, including mid-frame.
- PW = WIDTH+2*PAD, PH = HEIGHT+2*PAD; scan is row-major over PW x PH.
- FSM: IDLE -> SCAN on start; SCAN -> DRAIN after beat (PH-1, PW-1); DRAIN -> IDLE once all delay chains and pool logic are empty, with frame_done pulsed on that transition cycle.
- Beat: in SCAN, a padding position (row<PAD, row>=PH-PAD, col<PAD, col>=PW-PAD) is a beat every cycle with padding_valid=1 and in_ready=0. A data position has in_ready=1; it is a beat only when valid_in=1.
- counter_col/row are registered and show the position of the pending beat. They advance on each beat; col wraps at PW-1 with row+1; both return to 0 on entering DRAIN.
- valid_in_pipeline2D registered: 1 in the cycle after a beat with row>=2 and col>=2.
- valid_pipeline2D[i] is valid_in_pipeline2D delayed i+1 cycles; valid_in_bias = valid_pipeline2D[CONV_LAT-1]. valid_pipeline_bias has the same structure; valid_in_maxpooling = valid_pipeline_bias[BIAS_LAT-1].
- Pool geometry: OW=PW-2, OH=PH-2. Pool counters pc/pr (0..OW-1, 0..OH-1) advance on valid_in_maxpooling.
- valid_in_max = valid_in_maxpooling & pc[0]. valid_in_max1 = valid_in_max & pr[0]. valid_out = valid_in_max1 registered 1 cycle.
- Odd OW/OH: trailing column/row is counted but never strobes (floor).
- POOL=0: valid_in_max=valid_in_max1=0; valid_out = valid_in_maxpooling registered 1 cycle.
- start while busy: ignored. valid_in while in_ready=0: ignored; upstream must hold the pixel.
- DRAIN and IDLE: in_ready=0, padding_valid=0.

Optional Feature:
CTRL_LAYER_PROTO_CHECK_EN
- Defined: err is set when valid_in=1 and in_ready=0 in SCAN, or when start=1 while busy. err is cleared only by reset.
- Undefined: err is tied 0 and no check logic is built.

Decomposition:
- Package layer_ctrl_pkg: FSM state enum (IDLE, SCAN, DRAIN) and the pool-position helper function.
- Sub-module valid_delay_line, parameter DEPTH, with outputs tap vector and last tap. Instantiated twice: CONV_LAT and BIAS_LAT.

Test Plan:
- WIDTH=4, HEIGHT=4, PAD=1, valid_in held 1, one start: 36 beats, 20 with padding_valid, 16 in_ready accepts. 16 valid_in_pipeline2D, the first 1 cycle after beat (2,2). valid_in_maxpooling 10 cycles after each window. 4 valid_out. One frame_done, then busy=0.
- Same config, valid_in toggled 1-0: data beats stall and pad beats do not. Counts are identical to the first scenario; counters never skip or repeat.
- PAD=0, WIDTH=5, HEIGHT=5, POOL=1: 25 beats, no padding_valid. OW=OH=3 gives 1 valid_out; the trailing row/column are dropped.
- POOL=0, WIDTH=4, HEIGHT=4, PAD=1: valid_out count = 16, each 1 cycle after valid_in_maxpooling.
- rst=0 asserted mid-SCAN at beat 20: next cycle all outputs 0, IDLE. A new start produces a full clean frame.
- Macro defined: valid_in=1 during a padding beat -> err=1 and stays 1 until reset. Macro undefined -> err stays 0.
